// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu: single-outstanding load/store unit between EXU and WBU.
//
// Takes the ALU result as the effective address. For a legal access it
// issues one single-beat request on the memory port. Load data is aligned
// and extended before it is handed to write-back. Misaligned accesses,
// illegal sizes and response timeouts complete with out_err=1 and
// out_rdata=0, so the pipeline never hangs.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            EXU handshake
//   in_addr, in_wdata, in_memOp  effective address, store data, opcode
//                                (memOp: [3] store, [2] unsigned, [1:0] size)
//   mem_req_valid/mem_req_ready  memory request handshake
//   mem_addr, mem_wen            word-aligned address, write enable
//   mem_wdata, mem_wmask         lane-replicated store data, byte enables
//   mem_rsp_valid, mem_rdata     one-cycle response (read data or write ack)
//   out_valid/out_ready          WBU handshake
//   out_rdata, out_err           extended load data, error flag
//
// state | meaning
// IDLE  | ready to accept a new op
// REQ   | mem_req_valid high, request fields held until mem_req_ready
// WAIT  | request taken, counting cycles until response or timeout
// DONE  | out_valid high, result held until out_ready
module ysyx_23060061_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [3:0]  in_memOp,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]  state;
    logic [31:0] addrReg;
    logic [3:0]  memOpReg;
    logic        wenReg;
    logic [31:0] wdataReg;
    logic [3:0]  wmaskReg;
    logic [7:0]  waitCnt;
    logic [31:0] rdataReg;
    logic        errReg;

    logic        inBad;
    logic [3:0]  laneMask;
    logic [31:0] laneData;
    logic [31:0] shifted;
    logic [31:0] loadResult;

    // Alignment check and store lane placement on the incoming op, so the
    // request fields are registered once at accept and stay stable in REQ.
    always_comb begin
        inBad    = 1'b0;
        laneMask = 4'b1111;
        laneData = in_wdata;
        case (in_memOp[1:0])
            2'b00: begin
                laneMask = 4'b0001 << in_addr[1:0];
                laneData = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                inBad    = in_addr[0];
                laneMask = 4'b0011 << in_addr[1:0];
                laneData = {2{in_wdata[15:0]}};
            end
            2'b10: inBad = |in_addr[1:0];
            default: inBad = 1'b1;
        endcase
        if (!in_memOp[3]) begin
            laneMask = 4'b0000;
        end
    end

    // Bring the addressed byte/half down to bit 0, then extend.
    always_comb begin
        shifted    = mem_rdata >> {addrReg[1:0], 3'b000};
        loadResult = shifted;
        case (memOpReg[1:0])
            2'b00: loadResult = memOpReg[2] ? {24'b0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: loadResult = memOpReg[2] ? {16'b0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: loadResult = shifted;
        endcase
        if (memOpReg[3]) begin
            loadResult = 32'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addrReg  <= 32'b0;
            memOpReg <= 4'b0;
            wenReg   <= 1'b0;
            wdataReg <= 32'b0;
            wmaskReg <= 4'b0;
            waitCnt  <= 8'b0;
            rdataReg <= 32'b0;
            errReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        addrReg  <= in_addr;
                        memOpReg <= in_memOp;
                        wenReg   <= in_memOp[3];
                        wdataReg <= laneData;
                        wmaskReg <= laneMask;
                        rdataReg <= 32'b0;
                        errReg   <= inBad;
                        state    <= inBad ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        waitCnt <= 8'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the final counted cycle still wins.
                    if (mem_rsp_valid) begin
                        rdataReg <= loadResult;
                        errReg   <= 1'b0;
                        state    <= DONE;
                    end else if (waitCnt == TIMEOUT_CNT) begin
                        rdataReg <= 32'b0;
                        errReg   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready      = (state == IDLE) && rst_n;
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = {addrReg[31:2], 2'b00};
    assign mem_wen       = wenReg;
    assign mem_wdata     = wdataReg;
    assign mem_wmask     = wmaskReg;
    assign out_valid     = (state == DONE);
    assign out_rdata     = rdataReg;
    assign out_err       = errReg;

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
module tb_ysyx_23060061_lsu;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_memOp;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    ysyx_23060061_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_memOp(in_memOp),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic wen; logic [3:0] mask; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] rdata; logic err; } res_t;

    req_t reqQ[$];
    res_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Environment knobs shared by the stimulus, responder and monitor.
    int readyMode = 1;   // 0 random out_ready, 1 always, 2 held low
    bit fastMem   = 1;   // zero-delay ready and response
    bit noRsp     = 0;   // swallow responses (forces a timeout)
    bit forceRsp  = 0;   // one stray response pulse
    int nextStall = -1;  // forced mem_req_ready delay for the next request

    // Byte-addressed memories: refMem is the model's view, envMem is what
    // the responder actually serves using the DUT's request fields.
    logic [7:0] refMem [logic [31:0]];
    logic [7:0] envMem [logic [31:0]];

    function automatic logic [7:0] initByte(input logic [31:0] a);
        return 8'(a[7:0] * 8'd29 + a[15:8] + 8'h5A);
    endfunction

    function automatic logic [7:0] refByte(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initByte(a);
    endfunction

    function automatic logic [7:0] envByte(input logic [31:0] a);
        return envMem.exists(a) ? envMem[a] : initByte(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic abortRun(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "run aborted");
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            refMem[a + 32'(i)] = w[8*i +: 8];
            envMem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    // Reference model: derive request and result from the op using
    // byte-level memory, then present the op. Called at a negedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] op,
                         input bit tmo, output int acc);
        int    n;
        int    bytes;
        bit    bad;
        req_t  r;
        res_t  e;
        logic [31:0] v;
        bytes = 1 << op[1:0];
        bad = (op[1:0] == 2'd3) || (op[1:0] == 2'd1 && a[0]) || (op[1:0] == 2'd2 && a[1:0] != 2'd0);
        n = 0;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 500) abortRun("in_ready wait");
        end
        if (bad) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
        end else begin
            r.addr  = {a[31:2], 2'b00};
            r.wen   = op[3];
            r.mask  = 4'h0;
            r.wdata = 32'h0;
            if (op[3]) begin
                if (op[1:0] == 2'd0) begin
                    r.mask  = 4'(1 << a[1:0]);
                    r.wdata = {24'h0, wd[7:0]} * 32'h01010101;
                end else if (op[1:0] == 2'd1) begin
                    r.mask  = 4'(3 << a[1:0]);
                    r.wdata = {16'h0, wd[15:0]} * 32'h00010001;
                end else begin
                    r.mask  = 4'hF;
                    r.wdata = wd;
                end
                for (int i = 0; i < bytes; i++) refMem[a + 32'(i)] = wd[8*i +: 8];
                v = 32'h0;
            end else begin
                v = 32'h0;
                for (int i = 0; i < bytes; i++) v = v | (32'(refByte(a + 32'(i))) << (8*i));
                if (bytes < 4 && !op[2] && v[8*bytes-1]) v = v | ~((32'h1 << (8*bytes)) - 32'h1);
            end
            reqQ.push_back(r);
            e.rdata = tmo ? 32'h0 : v;
            e.err   = tmo;
        end
        expQ.push_back(e);
        in_valid = 1'b1;
        in_addr  = a;
        in_wdata = wd;
        in_memOp = op;
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_addr  = $urandom;
        in_wdata = $urandom;
        in_memOp = 4'($urandom);
    endtask

    task automatic waitOut(input int acc, input int lat, input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s actual=no out_valid expected=latency %0d", name, lat);
        end else begin
            check(name, 32'(cyc - acc), 32'(lat));
        end
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, " in_ready"},      32'(in_ready), 32'h0);
        check({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'h0);
        check({tag, " out_valid"},     32'(out_valid), 32'h0);
        check({tag, " out_err"},       32'(out_err), 32'h0);
        check({tag, " out_rdata"},     out_rdata, 32'h0);
        check({tag, " mem_wen"},       32'(mem_wen), 32'h0);
        check({tag, " mem_wmask"},     32'(mem_wmask), 32'h0);
        check({tag, " mem_wdata"},     mem_wdata, 32'h0);
        check({tag, " mem_addr"},      mem_addr, 32'h0);
    endtask

    // Pulse reset at the current negedge, check outputs, then release.
    task automatic midReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkQuiet(tag);
        expQ.delete();
        reqQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        noRsp = 1'b0;
        @(negedge clk);
        check({tag, " in_ready after release"}, 32'(in_ready), 32'h1);
        check({tag, " no replay"}, 32'(mem_req_valid), 32'h0);
    endtask

    // Memory responder: checks request fields every cycle they are offered.
    bit          pendHs = 0;
    bit          rspPending = 0;
    int          rspLeft = 0;
    int          stallLeft = -1;
    logic [31:0] rspData = 32'h0;

    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rdata     = $urandom;
            if (!rst_n) begin
                pendHs = 0;
                rspPending = 0;
                stallLeft = -1;
                mem_req_ready = 1'b0;
                continue;
            end
            if (pendHs) begin
                pendHs = 0;
                if (!noRsp) begin
                    rspPending = 1;
                    rspLeft = fastMem ? 0 : $urandom_range(0, 3);
                end
            end
            if (forceRsp) begin
                forceRsp = 0;
                mem_rsp_valid = 1'b1;
            end else if (rspPending) begin
                if (rspLeft == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = rspData;
                    rspPending = 0;
                end else begin
                    rspLeft--;
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (reqQ.size() == 0) begin
                    check("unexpected mem_req_valid", 32'(mem_req_valid), 32'h0);
                end else begin
                    check("req addr", mem_addr, reqQ[0].addr);
                    check("req wen", 32'(mem_wen), 32'(reqQ[0].wen));
                    check("req wmask", 32'(mem_wmask), 32'(reqQ[0].mask));
                    if (reqQ[0].wen) check("req wdata", mem_wdata, reqQ[0].wdata);
                    if (stallLeft < 0) begin
                        stallLeft = (nextStall >= 0) ? nextStall : (fastMem ? 0 : $urandom_range(0, 3));
                        nextStall = -1;
                    end
                    if (stallLeft == 0) begin
                        stallLeft = -1;
                        mem_req_ready = 1'b1;
                        pendHs = 1;
                        rspData = $urandom;
                        if (mem_wen) begin
                            for (int i = 0; i < 4; i++)
                                if (mem_wmask[i]) envMem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
                        end else begin
                            for (int i = 0; i < 4; i++) rspData[8*i +: 8] = envByte(mem_addr + 32'(i));
                        end
                        void'(reqQ.pop_front());
                    end else begin
                        stallLeft--;
                    end
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on each write-back handshake.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_ready = 1'b0;
                continue;
            end
            case (readyMode)
                0: out_ready = ($urandom_range(0, 3) != 0);
                1: out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    check("unexpected out_valid", 32'(out_valid), 32'h0);
                end else begin
                    e = expQ.pop_front();
                    check("out_rdata", out_rdata, e.rdata);
                    check("out_err", 32'(out_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        int acc;
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_addr = 32'h0;
        in_wdata = 32'h0;
        in_memOp = 4'h0;
        out_ready = 1'b0;
        #1;
        checkQuiet("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'h1);

        // Word load, immediate ready and response: 3-cycle latency.
        preload(32'h80000004, 32'hDEADBEEF);
        issue(32'h80000004, 32'h11111111, 4'b0010, 0, acc);
        waitOut(acc, 3, "word load latency");
        @(negedge clk);

        // Byte loads at offset 3, signed and unsigned.
        preload(32'h80000008, 32'h80123456);
        issue(32'h8000000B, 32'h0, 4'b0000, 0, acc);
        waitOut(acc, 3, "signed byte latency");
        @(negedge clk);
        issue(32'h8000000B, 32'h0, 4'b0100, 0, acc);
        waitOut(acc, 3, "unsigned byte latency");
        @(negedge clk);

        // Half store with the request stalled for 4 cycles.
        nextStall = 4;
        issue(32'h80000002, 32'h0000ABCD, 4'b1001, 0, acc);
        waitOut(acc, 7, "stalled store latency");
        @(negedge clk);
        issue(32'h80000000, 32'h0, 4'b0010, 0, acc);
        waitOut(acc, 3, "readback latency");
        @(negedge clk);

        // Misaligned word load: error one cycle after accept, no request.
        issue(32'h80000001, 32'h0, 4'b0010, 0, acc);
        waitOut(acc, 1, "misaligned latency");
        @(negedge clk);
        issue(32'h80000010, 32'h0, 4'b0011, 0, acc);
        waitOut(acc, 1, "illegal size latency");
        @(negedge clk);

        // Timeout, then a stray late response, then a normal access.
        noRsp = 1;
        issue(32'h80000010, 32'h0, 4'b0010, 1, acc);
        waitOut(acc, TMO + 3, "timeout latency");
        @(negedge clk);
        forceRsp = 1;
        noRsp = 0;
        repeat (3) @(negedge clk);
        check("stray rsp ignored", 32'(out_valid), 32'h0);
        issue(32'h80000014, 32'h0, 4'b0001, 0, acc);
        waitOut(acc, 3, "after timeout latency");
        @(negedge clk);

        // Reset in WAIT.
        noRsp = 1;
        issue(32'h80000020, 32'h0, 4'b0010, 0, acc);
        @(negedge clk);
        midReset("rst in WAIT");

        // Reset in DONE with out_ready held low.
        readyMode = 2;
        issue(32'h80000003, 32'hCAFEF00D, 4'b0010, 0, acc);
        waitOut(acc, 1, "done hold latency");
        @(negedge clk);
        check("out_valid held", 32'(out_valid), 32'h1);
        midReset("rst in DONE");
        readyMode = 1;
        issue(32'h80000004, 32'h0, 4'b0110, 0, acc);
        waitOut(acc, 3, "after reset latency");
        @(negedge clk);

        // Randomized traffic.
        readyMode = 0;
        fastMem = 0;
        for (int k = 0; k < 300; k++) begin
            issue(32'h80000000 + 32'($urandom_range(0, 31)), $urandom, 4'($urandom), 0, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while (expQ.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("results drained", 32'(expQ.size()), 32'h0);
        check("requests drained", 32'(reqQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060061_lsu.md
# ysyx_23060061_lsu

Load/store unit that sits directly downstream of the execute-stage ALU in the NPC core. It takes the ALU result as the effective address, together with the store data and a memory opcode from decode. It issues one single-beat request on a simple valid/ready memory port, aligns and extends load data, and hands the result to write-back on a valid/ready port. Only one access is in flight at a time; misaligned accesses and response timeouts are reported as errors without hanging the pipeline.

## Interface
- TIMEOUT, 255: maximum cycles spent in WAIT before the access is abandoned (1..255; counter is 8 bits).
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  EXU presents a memory op.
- in_ready  output  1  LSU can accept; equals (state==IDLE) and rst_n high.
- in_addr  input  32  effective address (ALU output).
- in_wdata  input  32  store data (rs2).
- in_memOp  input  4  bit3 store(1)/load(0); bit2 unsigned load; bits1:0 size (00 byte, 01 half, 10 word, 11 illegal).
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_addr  output  32  {addr[31:2],2'b00}.
- mem_wen  output  1  1 = write.
- mem_wdata  output  32  store data shifted into its byte lanes.
- mem_wmask  output  4  byte enables; 0 for loads.
- mem_rsp_valid  input  1  response (read data or write ack), one cycle.
- mem_rdata  input  32  read data, valid with mem_rsp_valid.
- out_valid  output  1  result available to WBU.
- out_ready  input  1  WBU accepts the result.
- out_rdata  output  32  extended load data; 0 for stores and errors.
- out_err  output  1  misaligned, illegal-size, or timed-out access.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset (rst_n low, immediate) forces IDLE and clears all registers. mem_req_valid, out_valid, out_err, out_rdata, mem_wen, mem_wmask, mem_wdata and mem_addr all read 0. in_ready reads 0 while rst_n is low.
- IDLE: on in_valid&&in_ready, latch addr, wdata and memOp. Compute off=addr[1:0].
  - If size==11, or half with off[0]=1, or word with off!=0: go to DONE with err=1. No memory request is made.
  - Otherwise go to REQ.
- REQ: assert mem_req_valid and hold mem_addr, mem_wen, mem_wdata and mem_wmask stable until mem_req_ready. On the handshake, go to WAIT and clear the timeout counter.
- WAIT: on mem_rsp_valid, capture the result and go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT, go to DONE with err=1 and rdata=0.
- DONE: assert out_valid with out_rdata and out_err stable. On out_ready, return to IDLE.
- Store lanes: byte gives mask 0001<<off and wdata {4{wdata[7:0]}}. Half gives mask 0011<<off and wdata {2{wdata[15:0]}}. Word gives mask 1111 and wdata as-is.
- Load extract: d = mem_rdata >> (8*off).
  - Byte: sign- or zero-extend d[7:0].
  - Half: sign- or zero-extend d[15:0].
  - Word: d. The unsigned bit is ignored for word loads.
- Store completion: the response (rdata ignored) gives out_rdata=0, out_err=0.
- mem_rsp_valid outside WAIT is ignored, including a late response after a timeout. mem_req_ready outside REQ is ignored.
- rst_n asserted in any state aborts the access. No request is replayed after reset release.

## Timing
- Accept at edge T gives state REQ at T+1. With mem_req_ready=1 in that cycle, WAIT starts at T+2. With mem_rsp_valid at T+2, out_valid rises at T+3. Minimum load-to-result latency is 3 cycles.
- Misaligned or illegal access: out_valid at T+1.
- Timeout: out_valid exactly TIMEOUT+1 cycles after entering WAIT when no response arrives.
- in_ready is low from REQ through DONE. The next op can be accepted in the cycle after the DONE handshake (no same-cycle turnaround).
- All handshakes transfer on the rising edge where valid and ready are both high. Outputs are driven from registered state and are never combinationally dependent on ready inputs.

## Test plan
- Word load at 0x80000004, memory returns 0xDEADBEEF with ready and rsp immediate: mem_wmask=0, out_rdata=0xDEADBEEF, out_valid 3 cycles after accept.
- Signed byte load at off=3 with rdata 0x80123456: out_rdata=0xFFFFFF80. The unsigned variant gives 0x00000080.
- Half store of 0x0000ABCD at 0x80000002, mem_req_ready held low 4 cycles: request fields stable throughout. Expect mask=1100, wdata=0xABCDABCD, out_err=0.
- Word load at 0x80000001: no mem_req_valid ever. out_valid and out_err=1 one cycle after accept.
- TIMEOUT=4 with no response: out_err=1, out_rdata=0 after 5 WAIT cycles. A later mem_rsp_valid is ignored and the next access completes normally.
- rst_n pulsed low mid-WAIT, and separately in DONE with out_ready=0: all outputs are 0 immediately. in_ready is 1 on the first cycle after release.
